// File: rtl/conv_pool_mc.sv
// conv_pool_mc: streams 4x4 8-bit image blocks from a 1-cycle-latency memory,
// applies NUM_KERNELS signed 3x3 kernels (2x2 conv map each), pools each map
// (max or average), shifts, applies ReLU and saturates to one byte per kernel.
// Optional feature macro: CONV_POOL_BIAS_EN adds a per-kernel signed 16-bit
// bias (port conv_bias) added to the pooled value before shift/ReLU/saturation.
module conv_pool_mc #(
  parameter int NUM_KERNELS = 3,
  parameter int ADDR_W      = 16,
  parameter int SHIFT_W     = 2,
  parameter int ACC_W       = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          num_blocks,
  output logic                       busy,
  output logic                       done,
  output logic                       input_re,
  output logic [ADDR_W-1:0]          input_addr,
  input  logic [127:0]               image_4x4,
  input  logic [NUM_KERNELS*72-1:0]  conv_kernel,
`ifdef CONV_POOL_BIAS_EN
  input  logic [NUM_KERNELS*16-1:0]  conv_bias,
`endif
  input  logic [SHIFT_W-1:0]         shift,
  input  logic                       pool_mode,
  output logic [NUM_KERNELS-1:0]     output_we,
  output logic [ADDR_W-1:0]          output_addr,
  output logic [NUM_KERNELS*8-1:0]   y
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic signed [ACC_W+1:0] SAT_MAX = (ACC_W+2)'(255);

  logic [1:0]                  state;
  logic [ADDR_W-1:0]           nb_r;
  logic [NUM_KERNELS*72-1:0]   kern_r;
  logic [SHIFT_W-1:0]          shift_r;
  logic                        mode_r;
`ifdef CONV_POOL_BIAS_EN
  logic [NUM_KERNELS*16-1:0]   bias_r;
`endif

  // Pipeline: rd_* = read in flight, cap_* = captured block, conv_* = conv map.
  logic                        rd_v, cap_v, conv_v;
  logic [ADDR_W-1:0]           rd_addr, cap_addr, conv_addr;
  logic [127:0]                cap_img;
  logic signed [ACC_W-1:0]     conv_c [NUM_KERNELS][4];
  logic signed [ACC_W-1:0]     conv_r [NUM_KERNELS][4];
  logic [NUM_KERNELS*8-1:0]    res;

  function automatic logic signed [ACC_W+1:0] ext(input logic signed [ACC_W-1:0] v);
    return {{2{v[ACC_W-1]}}, v};
  endfunction

  // Control FSM: latches run configuration at start and issues block reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      input_re   <= 1'b0;
      input_addr <= '0;
      nb_r       <= '0;
      kern_r     <= '0;
      shift_r    <= '0;
      mode_r     <= 1'b0;
`ifdef CONV_POOL_BIAS_EN
      bias_r     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            nb_r    <= num_blocks;
            kern_r  <= conv_kernel;
            shift_r <= shift;
            mode_r  <= pool_mode;
`ifdef CONV_POOL_BIAS_EN
            bias_r  <= conv_bias;
`endif
            busy    <= 1'b1;
            if (num_blocks == '0) begin
              state <= S_DRAIN;
            end else begin
              state      <= S_RUN;
              input_re   <= 1'b1;
              input_addr <= '0;
            end
          end
        end
        S_RUN: begin
          if (input_addr == nb_r - 1'b1) begin
            input_re <= 1'b0;
            state    <= S_DRAIN;
          end else begin
            input_addr <= input_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          // The final write may still be on output_we in this cycle.
          if (!rd_v && !cap_v && !conv_v) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Valid/address pipeline and registered write outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_v        <= 1'b0;
      cap_v       <= 1'b0;
      conv_v      <= 1'b0;
      rd_addr     <= '0;
      cap_addr    <= '0;
      conv_addr   <= '0;
      output_we   <= '0;
      output_addr <= '0;
      y           <= '0;
    end else begin
      rd_v      <= input_re;
      rd_addr   <= input_addr;
      cap_v     <= rd_v;
      cap_addr  <= rd_addr;
      conv_v    <= cap_v;
      conv_addr <= cap_addr;
      output_we <= {NUM_KERNELS{conv_v}};
      if (conv_v) begin
        output_addr <= conv_addr;
        y           <= res;
      end
    end
  end

  // Data registers: image capture and conv map (no reset needed, gated by valids).
  always_ff @(posedge clk) begin
    if (rd_v) cap_img <= image_4x4;
    if (cap_v) conv_r <= conv_c;
  end

  // 3x3 convolution of the captured block into a 2x2 map per kernel.
  always_comb begin
    logic signed [ACC_W-1:0] acc;
    logic [7:0]              pix;
    logic [7:0]              wgt;
    acc = '0;
    pix = '0;
    wgt = '0;
    for (int unsigned n = 0; n < NUM_KERNELS; n++) begin
      for (int unsigned a = 0; a < 2; a++) begin
        for (int unsigned b = 0; b < 2; b++) begin
          acc = '0;
          for (int unsigned i = 0; i < 3; i++) begin
            for (int unsigned j = 0; j < 3; j++) begin
              pix = cap_img[8*((a+i)*4+b+j) +: 8];
              wgt = kern_r[72*n + 8*(i*3+j) +: 8];
              acc = acc + ($signed({{(ACC_W-8){1'b0}}, pix}) *
                           $signed({{(ACC_W-8){wgt[7]}}, wgt}));
            end
          end
          conv_c[n][a*2+b] = acc;
        end
      end
    end
  end

  // Pool, optional bias, arithmetic shift, ReLU and 8-bit saturation.
  always_comb begin
    logic signed [ACC_W+1:0] sum;
    logic signed [ACC_W-1:0] mx;
    logic signed [ACC_W+1:0] pooled;
    logic signed [ACC_W+1:0] shifted;
    res     = '0;
    sum     = '0;
    mx      = '0;
    pooled  = '0;
    shifted = '0;
    for (int unsigned n = 0; n < NUM_KERNELS; n++) begin
      sum = ext(conv_r[n][0]) + ext(conv_r[n][1]) + ext(conv_r[n][2]) + ext(conv_r[n][3]);
      mx  = conv_r[n][0];
      for (int unsigned q = 1; q < 4; q++) begin
        if (conv_r[n][q] > mx) mx = conv_r[n][q];
      end
      pooled = mode_r ? (sum >>> 2) : ext(mx);
`ifdef CONV_POOL_BIAS_EN
      pooled = pooled + $signed({{(ACC_W-14){bias_r[16*n+15]}}, bias_r[16*n +: 16]});
`endif
      shifted = pooled >>> shift_r;
      if (shifted[ACC_W+1])
        res[8*n +: 8] = 8'h00;
      else if (shifted > SAT_MAX)
        res[8*n +: 8] = 8'hFF;
      else
        res[8*n +: 8] = shifted[7:0];
    end
  end

endmodule

// File: doc/conv_pool_mc.md
Name: conv_pool_mc

Overview:
- Parametrised successor to the three-kernel conv/pool engine.
- Streams NUM_BLOCKS-many 4x4 8-bit image blocks from a 1-cycle-latency read memory.
- Applies NUM_KERNELS signed 3x3 kernels to each block, producing a 2x2 conv map per kernel.
- Pools each map to one value (max or average, run-time selectable), then right-shifts, applies ReLU and saturates to 8 bits.
- Writes one byte per kernel per block to the per-kernel result memories through a shared address.

Parameters:
NUM_KERNELS, 3, number of parallel kernels/output channels
ADDR_W, 16, width of block count and of input/output addresses
SHIFT_W, 2, width of shift control
ACC_W, 20, signed conv accumulator width; must be at least 20

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle run request, honoured only in IDLE
num_blocks  in  ADDR_W  blocks to process; sampled at start
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the last write
input_re  out  1  read enable to image memory
input_addr  out  ADDR_W  block address
image_4x4  in  128  block data, valid the cycle after input_re; pixel k=r*4+c at bits [8k+7:8k], unsigned
conv_kernel  in  NUM_KERNELS*72  kernel n at bits [72n+71:72n]; weight m=i*3+j at bits [8m+7:8m] of that slice, signed
shift  in  SHIFT_W  arithmetic right shift applied after pooling
pool_mode  in  1  0=max pool, 1=average pool
output_we  out  NUM_KERNELS  per-kernel write enable
output_addr  out  ADDR_W  shared write address
y  out  NUM_KERNELS*8  result for kernel n at bits [8n+7:8n]

Behaviour:
- Reset: busy, done, input_re, output_we set to 0; input_addr, output_addr, y set to 0; FSM goes to IDLE; all pipeline valids cleared. Reset is effective immediately, including mid-run; no further writes occur.
- FSM states:
  - IDLE: on start, latch num_blocks, conv_kernel, shift and pool_mode into internal registers. Go to RUN, or to DRAIN if num_blocks=0. Input changes during a run have no effect.
  - RUN: input_re=1 every cycle, input_addr = 0,1,…,num_blocks-1 on consecutive cycles. After the last address, go to DRAIN.
  - DRAIN: wait for pipeline valids to empty, then go to DONE.
  - DONE: done=1 for one cycle, then return to IDLE.
- start is ignored outside IDLE.
- For num_blocks=0, no reads or writes occur; done pulses 2 cycles after start.
- Pipeline, with a read issued at cycle t:
  - t+1: image_4x4 captured.
  - t+2: conv C(a,b) = Σ p[a+i][b+j]·w[i][j] for a,b∈{0,1}, signed ACC_W, no overflow possible.
  - t+3: pool. Max = signed max of four; avg = (sum of four) >>> 2, arithmetic shift, computed with ACC_W+2 bits.
  - t+4: result = pooled >>> shift; negative → 0; >255 → 255. output_we = all ones, output_addr = t's address, y = result.
- Fixed latency is 4 cycles; throughput is 1 block/cycle.
- busy stays high through DRAIN and DONE; done coincides with busy falling.
- Max address is 2^ADDR_W-1; num_blocks is not wrapped.

Optional Feature:
- Macro CONV_POOL_BIAS_EN.
- Defined:
  - Adds input port conv_bias, NUM_KERNELS*16 signed; kernel n at bits [16n+15:16n], latched at start.
  - Bias is sign-extended and added to the pooled value in the t+3 stage, before shift/ReLU/saturation.
  - Latency is unchanged.
- Undefined: the port is absent and behaviour is as above.

Test Plan:
- All pixels 1, all weights 1, shift 0, max, num_blocks=1, start at cycle s → input_re at s+1 (addr 0); output_we=111 at s+5 with y=9 on each kernel; done at s+6.
- Kernel weights all -1 (0xFF), pixels 1 → pooled -9 → y=0 (ReLU).
- Pixels 255, weights 127, shift 3 → 291465>>>3=36433 → y=255 (saturation).
- Kernel with only w[1][1]=1; p5=10, p6=20, p9=30, p10=41 → pool_mode 0 gives y=41; pool_mode 1 gives y=25. With CONV_POOL_BIAS_EN and bias=-20, mode 0 gives y=21.
- num_blocks=4, second start pulsed while busy → reads addr 0..3 on consecutive cycles, writes 0..3 on consecutive cycles, single done pulse, second start ignored; num_blocks=0 → done at s+2 with no reads.
- rst asserted after 2 reads → outputs 0 in the same cycle; no output_we ever; busy 0; a new start afterwards restarts at addr 0.
